// File: rtl/spi_slave_if.sv
// SPI pins plus the parallel byte side of the SPI slave, bundled as one port.
// Combinational bundle, no latency. No backpressure; the SPI master sets all timing.
interface spi_slave_if #(
    parameter int WIDTH = 8
);
    logic             ss;
    logic             sck;
    logic             mosi;
    logic             miso;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             new_data;

    modport slave (
        input  ss, sck, mosi, data_in,
        output miso, data_out, busy, new_data
    );

    modport master (
        output ss, sck, mosi, data_in,
        input  miso, data_out, busy, new_data
    );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampled on clk; SPI_SLAVE_MISO_HIZ_EN tristates miso when idle.
// Latency: new_data rises SYNC_STAGES+1 clk after the last sck rise at the pin.
// Backpressure: none; data_in is sampled at each frame load and data_out must be taken on new_data.
module spi_slave #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    spi_slave_if.slave  bus
);
    // Fewer than two stages is not a safe synchronizer, so the depth is clamped.
    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [NS-1:0]    ss_pipe;
    logic [NS-1:0]    sck_pipe;
    logic [NS-1:0]    mosi_pipe;
    logic [NS-1:0]    fill;
    logic             sck_prev;
    logic             armed;

    logic             ss_s;
    logic             sck_s;
    logic             mosi_s;
    logic             sck_rise;
    logic             sck_fall;

    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] rx_next;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] data_out_q;
    logic             new_data_q;

    logic             start_frame;
    logic             end_frame;
    logic             sample;
    logic             shift_out;

    assign ss_s     = ss_pipe[NS-1];
    assign sck_s    = sck_pipe[NS-1];
    assign mosi_s   = mosi_pipe[NS-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign rx_next  = {rx_shift[WIDTH-2:0], mosi_s};

    // fill marks when the chain holds real pin samples rather than reset values;
    // armed then requires a genuine high ss before any frame may start.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_pipe   <= '1;
            sck_pipe  <= '0;
            mosi_pipe <= '0;
            sck_prev  <= 1'b0;
            fill      <= '0;
            armed     <= 1'b0;
        end else begin
            ss_pipe   <= {ss_pipe[NS-2:0], bus.ss};
            sck_pipe  <= {sck_pipe[NS-2:0], bus.sck};
            mosi_pipe <= {mosi_pipe[NS-2:0], bus.mosi};
            sck_prev  <= sck_s;
            fill      <= {fill[NS-2:0], 1'b1};
            if (fill[NS-1] && ss_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ss wins over any sck edge seen in the same cycle.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        sample      = 1'b0;
        shift_out   = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !ss_s) begin
                    state_next  = ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_s) begin
                    state_next = IDLE;
                    end_frame  = 1'b1;
                end else if (sck_rise) begin
                    sample = 1'b1;
                end else if (sck_fall && (bit_cnt != '0)) begin
                    shift_out = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The falling edge right after a wrap is skipped so the freshly reloaded MSB stays on miso.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            data_out_q <= '0;
            new_data_q <= 1'b0;
        end else begin
            new_data_q <= 1'b0;
            if (start_frame || end_frame) begin
                bit_cnt <= '0;
            end
            if (start_frame) begin
                tx_shift <= bus.data_in;
            end
            if (sample) begin
                rx_shift <= rx_next;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt    <= '0;
                    data_out_q <= rx_next;
                    new_data_q <= 1'b1;
                    tx_shift   <= bus.data_in;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
            if (shift_out) begin
                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.new_data = new_data_q;
    assign bus.busy     = (state == ACTIVE);

`ifdef SPI_SLAVE_MISO_HIZ_EN
    assign bus.miso = ((state == ACTIVE) && !rst) ? tx_shift[WIDTH-1] : 1'bz;
`else
    assign bus.miso = ((state == ACTIVE) && !rst) ? tx_shift[WIDTH-1] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural mode-0 master drives frames and checks results.
module tb_spi_slave;
    localparam int W    = 8;
    localparam int SYNC = 2;
`ifdef SPI_SLAVE_MISO_HIZ_EN
    localparam logic MISO_IDLE = 1'bz;
`else
    localparam logic MISO_IDLE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_if #(.WIDTH(W)) bus ();

    spi_slave #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp   = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int nd_cnt  = 0;
    int nd_wide = 0;
    int nd_cyc  = 0;
    int rise_cyc = 0;
    logic nd_prev = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.new_data === 1'b1) begin
            nd_cnt++;
            nd_cyc = cyc;
            if (nd_prev) nd_wide++;
        end
        nd_prev = (bus.new_data === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the top nbits of tx MSB first; returns what was seen on miso at each rise.
    task automatic frame(input logic [W-1:0] tx, input int nbits, input int half,
                         output logic [W-1:0] rx);
        rx = '0;
        for (int i = W - 1; i >= W - nbits; i--) begin
            bus.mosi = tx[i];
            wait_clk(half);
            bus.sck = 1'b1;
            rx[i]   = bus.miso;
            if (i == W - nbits) rise_cyc = cyc;
            wait_clk(half);
            bus.sck = 1'b0;
        end
    endtask

    logic [W-1:0] rx;
    int nd_base;

    initial begin
        bus.ss      = 1'b1;
        bus.sck     = 1'b0;
        bus.mosi    = 1'b0;
        bus.data_in = 8'hA5;
        wait_clk(4);
        chk("rst data_out", bus.data_out, 8'h00);
        chk("rst busy", bus.busy, 1'b0);
        chk("rst new_data", bus.new_data, 1'b0);
        chk("rst miso", bus.miso, MISO_IDLE);
        rst = 1'b0;
        wait_clk(6);

        // Single frame at 5 MHz sck
        bus.ss = 1'b0;
        wait_clk(10);
        chk("f1 busy", bus.busy, 1'b1);
        frame(8'h5C, 8, 10, rx);
        chk("f1 data_out", bus.data_out, 8'h5C);
        chk("f1 new_data count", nd_cnt, 1);
        chk("f1 miso byte", rx, 8'hA5);
        chk("f1 latency ok", ((nd_cyc - rise_cyc) >= 1) && ((nd_cyc - rise_cyc) <= SYNC + 2), 1'b1);
        wait_clk(10);
        chk("f1 busy held", bus.busy, 1'b1);
        bus.ss = 1'b1;
        wait_clk(10);
        chk("f1 busy fall", bus.busy, 1'b0);

        // sck activity while deselected
        nd_base = nd_cnt;
        for (int k = 0; k < 4; k++) begin
            bus.sck = 1'b1;
            wait_clk(10);
            bus.sck = 1'b0;
            wait_clk(10);
        end
        chk("idle sck new_data", nd_cnt, nd_base);
        chk("idle sck data_out", bus.data_out, 8'h5C);
        chk("idle sck busy", bus.busy, 1'b0);
        chk("idle sck miso", bus.miso, MISO_IDLE);

        // Back-to-back frames with ss held low
        bus.data_in = 8'h11;
        nd_base = nd_cnt;
        bus.ss = 1'b0;
        wait_clk(10);
        bus.data_in = 8'h22;
        frame(8'h3C, 8, 10, rx);
        chk("b2b rx1", rx, 8'h11);
        chk("b2b data_out1", bus.data_out, 8'h3C);
        chk("b2b nd1", nd_cnt, nd_base + 1);
        frame(8'hC3, 8, 10, rx);
        chk("b2b rx2", rx, 8'h22);
        chk("b2b data_out2", bus.data_out, 8'hC3);
        chk("b2b nd2", nd_cnt, nd_base + 2);
        wait_clk(10);
        bus.ss = 1'b1;
        wait_clk(10);

        // Partial frame aborted by ss rise
        bus.data_in = 8'hA5;
        bus.ss = 1'b0;
        wait_clk(10);
        frame(8'h5C, 8, 10, rx);
        chk("abort pre data_out", bus.data_out, 8'h5C);
        bus.ss = 1'b1;
        wait_clk(10);
        nd_base = nd_cnt;
        bus.ss = 1'b0;
        wait_clk(10);
        frame(8'hFF, 5, 10, rx);
        bus.ss = 1'b1;
        wait_clk(10);
        chk("abort new_data", nd_cnt, nd_base);
        chk("abort data_out", bus.data_out, 8'h5C);
        chk("abort busy", bus.busy, 1'b0);
        bus.ss = 1'b0;
        wait_clk(10);
        frame(8'h81, 8, 10, rx);
        chk("abort next data_out", bus.data_out, 8'h81);
        bus.ss = 1'b1;
        wait_clk(10);

        // Reset mid-frame
        nd_base = nd_cnt;
        bus.ss = 1'b0;
        wait_clk(10);
        frame(8'hF0, 4, 10, rx);
        wait_clk(1);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        chk("midrst data_out", bus.data_out, 8'h00);
        chk("midrst busy", bus.busy, 1'b0);
        chk("midrst new_data", bus.new_data, 1'b0);
        chk("midrst miso", bus.miso, MISO_IDLE);
        wait_clk(12);
        chk("midrst no restart", bus.busy, 1'b0);
        chk("midrst nd", nd_cnt, nd_base);
        bus.ss = 1'b1;
        wait_clk(10);
        bus.ss = 1'b0;
        wait_clk(10);
        frame(8'h7E, 8, 10, rx);
        chk("postrst data_out", bus.data_out, 8'h7E);
        chk("postrst miso byte", rx, 8'hA5);
        bus.ss = 1'b1;
        wait_clk(10);

        // Minimum sck half-period
        nd_base = nd_cnt;
        bus.ss = 1'b0;
        wait_clk(SYNC + 2);
        frame(8'hAA, 8, SYNC + 2, rx);
        chk("fast data_out", bus.data_out, 8'hAA);
        chk("fast nd", nd_cnt, nd_base + 1);
        chk("fast miso byte", rx, 8'hA5);
        chk("fast latency ok", ((nd_cyc - rise_cyc) >= 1) && ((nd_cyc - rise_cyc) <= SYNC + 2), 1'b1);
        bus.ss = 1'b1;
        wait_clk(10);
        chk("new_data width", nd_wide, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter WIDTH, default 8: bits per SPI frame.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2: flip-flop stages on each of ss, sck and mosi.
REQ-003 clk  input  1  system clock; all logic SHALL be clocked on its rising edge; one clock domain only.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 ss  input  1  slave select from the master, active-low, asynchronous to clk.
REQ-006 sck  input  1  serial clock from the master, asynchronous to clk; idles low.
REQ-007 mosi  input  1  serial data from the master, asynchronous to clk.
REQ-008 miso  output  1  serial data to the master.
REQ-009 data_in  input  WIDTH  byte to transmit; sampled at each frame-load point.
REQ-010 data_out  output  WIDTH  last complete byte received.
REQ-011 busy  output  1  high while synchronized ss is low.
REQ-012 new_data  output  1  one-clk strobe; data_out was updated this cycle.

Function
REQ-013 The block SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first: sample on the sck rising edge, shift on the falling edge.
REQ-014 ss, sck and mosi SHALL each pass through SYNC_STAGES flip-flops before use; sck edges SHALL be detected by comparing the synchronized value with one further registered copy.
REQ-015 The FSM SHALL have two states: IDLE (synchronized ss high) and ACTIVE (synchronized ss low); busy SHALL equal (state == ACTIVE).
REQ-016 IDLE->ACTIVE on synchronized ss falling: bit counter cleared to 0; tx shift register loaded from data_in; miso SHALL present tx_shift[WIDTH-1] in the same cycle.
REQ-017 In ACTIVE, a detected sck rising edge SHALL shift synchronized mosi into the LSB of rx_shift and increment the bit counter.
REQ-018 When the increment wraps the counter from WIDTH-1 to 0, data_out SHALL be loaded with the completed byte, new_data SHALL pulse high for exactly one clk, and tx_shift SHALL be reloaded from data_in.
REQ-019 In ACTIVE, a detected sck falling edge SHALL shift tx_shift left by one when counter != 0, and SHALL be ignored when counter == 0; this preserves the reloaded MSB.
REQ-020 Back-to-back frames without ss deassertion SHALL be supported with no gap.
REQ-021 ACTIVE->IDLE on synchronized ss rising: counter cleared; a partial frame is discarded; data_out is unchanged; no new_data pulse.
REQ-022 An sck edge detected in the same cycle as the ss rise SHALL be ignored, because ss takes priority.
REQ-023 sck edges detected in IDLE SHALL be ignored.
REQ-024 new_data SHALL assert within SYNC_STAGES+2 clk cycles of the WIDTH-th sck rising edge at the pin.
REQ-025 Correct operation SHALL be guaranteed when the sck high time and the sck low time are each at least SYNC_STAGES+2 clk periods.

Reset
REQ-026 While rst is high, at the clk rising edge the block SHALL apply: state=IDLE, counter=0, rx_shift=0, tx_shift=0, data_out=0, new_data=0, busy=0, miso=0.
REQ-027 On reset, synchronizer registers SHALL be set to the idle values ss=1, sck=0, mosi=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no new_data pulse.
REQ-029 After reset, a frame SHALL begin only on a fresh ss falling edge.

Configuration
REQ-030 Macro SPI_SLAVE_MISO_HIZ_EN defined: miso SHALL be high-impedance whenever state == IDLE or rst is high.
REQ-031 Macro SPI_SLAVE_MISO_HIZ_EN undefined: miso SHALL be driven 0 in IDLE; ACTIVE behaviour is identical in both builds.

Verification
REQ-032 clk 100 MHz, sck 5 MHz, data_in=8'hA5; master sends 8'h5C in one frame -> data_out=8'h5C with a single new_data pulse; master captures 8'hA5 on miso; busy high exactly while ss is low.
REQ-033 Two back-to-back frames, ss held low; master sends 8'h3C then 8'hC3; data_in changes 8'h11->8'h22 before the second load -> new_data pulses twice; data_out reads 8'h3C then 8'hC3; master receives 8'h11 then 8'h22.
REQ-034 ss deasserted after 5 sck rises of 8'hFF, following a completed 8'h5C frame -> no new_data; data_out stays 8'h5C; busy falls; the next full frame of 8'h81 gives data_out=8'h81.
REQ-035 rst pulsed one clk after 4 sck rises -> all outputs at reset values next cycle; a subsequent full frame 8'h7E is received correctly.
REQ-036 sck toggled with ss high -> no state change; new_data stays 0; miso=0, or Z when SPI_SLAVE_MISO_HIZ_EN is defined.
REQ-037 Minimum sck half-period of SYNC_STAGES+2 clk, frame 8'hAA -> data_out=8'hAA; new_data asserts within SYNC_STAGES+2 clk of the 8th sck rise.
